// File: rtl/block_mover_if.sv
// Handshake bundle between the game controller and the moving-block generator.
// The controller drives the master side; block_mover sits on the slave side.
interface block_mover_if;
  logic       start_level;
  logic [3:0] block_size_in;
  logic [1:0] speed;
  logic       stop_btn;
  logic [8:0] curr_block_start;
  logic [8:0] curr_block_end;
  logic [3:0] curr_block_size;
  logic       stop_true;
  logic       moving;

  modport master (
    output start_level, block_size_in, speed, stop_btn,
    input  curr_block_start, curr_block_end, curr_block_size, stop_true, moving
  );

  modport slave (
    input  start_level, block_size_in, speed, stop_btn,
    output curr_block_start, curr_block_end, curr_block_size, stop_true, moving
  );
endinterface

// File: rtl/block_mover.sv
// Moving block of the block-stacker game: slides across the playfield, bounces off the
// walls at a programmable tick rate and freezes on a rising edge of the stop button.
module block_mover #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned CELL_W   = 16,
  parameter int unsigned STEP_PX  = 16,
  parameter int unsigned TICK_DIV = 1666666
) (
  input logic          clk,
  input logic          reset,
  block_mover_if.slave bus
);

  localparam int unsigned MaxCells = SCREEN_W / CELL_W;
  localparam int unsigned CntW     = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {StIdle, StMove, StStopped} state_e;

  state_e          state_q;
  logic            dir_left_q;
  logic [1:0]      speed_q;
  logic [CntW-1:0] cnt_q;
  logic            stop_prev_q;
  logic [8:0]      start_q;
  logic [8:0]      end_q;
  logic [3:0]      size_q;
  logic            stop_true_q;
  logic            moving_q;

  logic [3:0]      size_new;
  logic [8:0]      width_new;
  logic [8:0]      width_cur;
  int unsigned     period;
  logic [CntW-1:0] period_m1;
  logic            tick;
  logic            stop_edge;
  logic            fits_right;
  logic            can_left;
  logic [8:0]      step_start;
  logic            step_dir_left;

  assign size_new  = (32'(bus.block_size_in) > MaxCells) ? 4'(MaxCells) : bus.block_size_in;
  assign width_new = 9'(32'(size_new) * CELL_W);
  assign width_cur = 9'(32'(size_q) * CELL_W);

  // A shift that underflows to zero degrades to a step every cycle.
  assign period    = TICK_DIV >> speed_q;
  assign period_m1 = (period == 0) ? '0 : CntW'(period - 1);
  assign tick      = (cnt_q == period_m1);
  assign stop_edge = bus.stop_btn & ~stop_prev_q;

  // Compared in 32 bits so start+width+step cannot wrap the 9-bit position.
  assign fits_right = (32'(start_q) + 32'(width_cur) + STEP_PX) <= SCREEN_W;
  assign can_left   = 32'(start_q) >= STEP_PX;

  always_comb begin
    step_start    = start_q;
    step_dir_left = dir_left_q;
    if (!dir_left_q) begin
      if (fits_right) begin
        step_start = start_q + 9'(STEP_PX);
      end else begin
        step_dir_left = 1'b1;
        if (can_left) step_start = start_q - 9'(STEP_PX);
      end
    end else begin
      if (can_left) begin
        step_start = start_q - 9'(STEP_PX);
      end else begin
        step_dir_left = 1'b0;
        if (fits_right) step_start = start_q + 9'(STEP_PX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dir_left_q  <= 1'b0;
      speed_q     <= '0;
      cnt_q       <= '0;
      stop_prev_q <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      size_q      <= '0;
      stop_true_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      stop_prev_q <= bus.stop_btn;
      if (bus.start_level) begin
        stop_true_q <= 1'b0;
        if (size_new != '0) begin
          state_q    <= StMove;
          moving_q   <= 1'b1;
          dir_left_q <= 1'b0;
          speed_q    <= bus.speed;
          cnt_q      <= '0;
          size_q     <= size_new;
          start_q    <= '0;
          end_q      <= width_new - 9'd1;
        end else begin
          // Zero-size block means game over: park in idle, position held.
          state_q  <= StIdle;
          moving_q <= 1'b0;
        end
      end else begin
        case (state_q)
          StMove: begin
            if (stop_edge) begin
              state_q     <= StStopped;
              stop_true_q <= 1'b1;
              moving_q    <= 1'b0;
              cnt_q       <= '0;
            end else if (tick) begin
              cnt_q      <= '0;
              dir_left_q <= step_dir_left;
              start_q    <= step_start;
              end_q      <= step_start + width_cur - 9'd1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StIdle, StStopped: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.curr_block_start = start_q;
  assign bus.curr_block_end   = end_q;
  assign bus.curr_block_size  = size_q;
  assign bus.stop_true        = stop_true_q;
  assign bus.moving           = moving_q;

endmodule

// File: tb/tb_block_mover.sv
// Randomized bench for block_mover against a behavioural game-rule model, with a few
// directed scenarios (reset, first step, wall bounce, stop hold, game over, full width).
module tb_block_mover;

  localparam int unsigned SCREEN_W = 64;
  localparam int unsigned CELL_W   = 8;
  localparam int unsigned STEP_PX  = 8;
  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic reset;

  block_mover_if bus ();

  block_mover #(
    .SCREEN_W (SCREEN_W),
    .CELL_W   (CELL_W),
    .STEP_PX  (STEP_PX),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the game rules
  int m_pos, m_size, m_period, m_phase;
  bit m_right, m_moving, m_stopped, m_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_move();
    int w = m_size * CELL_W;
    for (int attempt = 0; attempt < 2; attempt++) begin
      if (m_right) begin
        if (m_pos + w + STEP_PX <= SCREEN_W) begin
          m_pos += STEP_PX;
          return;
        end
      end else if (m_pos >= STEP_PX) begin
        m_pos -= STEP_PX;
        return;
      end
      if (attempt == 0) m_right = !m_right;
    end
  endtask

  task automatic model_update(input bit r, input bit st, input int sz, input int sp,
                              input bit b);
    bit rise;
    if (r) begin
      m_pos = 0; m_size = 0; m_period = TICK_DIV; m_phase = 0;
      m_right = 1; m_moving = 0; m_stopped = 0; m_prev = 0;
      return;
    end
    rise   = b && !m_prev;
    m_prev = b;
    if (st) begin
      int eff = (sz > SCREEN_W / CELL_W) ? SCREEN_W / CELL_W : sz;
      m_stopped = 0;
      if (eff == 0) begin
        m_moving = 0;
      end else begin
        m_size   = eff;
        m_pos    = 0;
        m_right  = 1;
        m_period = ((TICK_DIV >> sp) == 0) ? 1 : (TICK_DIV >> sp);
        m_phase  = 0;
        m_moving = 1;
      end
      return;
    end
    if (m_moving) begin
      if (rise) begin
        m_moving  = 0;
        m_stopped = 1;
        return;
      end
      m_phase++;
      if (m_phase == m_period) begin
        m_phase = 0;
        model_move();
      end
    end
  endtask

  // Compare at the falling edge, then drive the next inputs and advance the model.
  task automatic cyc(input bit r, input bit st, input int sz, input int sp, input bit b);
    int exp_end;
    @(negedge clk);
    exp_end = (m_size == 0) ? 0 : m_pos + m_size * CELL_W - 1;
    check_val("start", 32'(bus.curr_block_start), 32'(m_pos));
    check_val("end", 32'(bus.curr_block_end), 32'(exp_end));
    check_val("size", 32'(bus.curr_block_size), 32'(m_size));
    check_val("stop_true", 32'(bus.stop_true), 32'(m_stopped));
    check_val("moving", 32'(bus.moving), 32'(m_moving));
    reset             = r;
    bus.start_level   = st;
    bus.block_size_in = 4'(sz);
    bus.speed         = 2'(sp);
    bus.stop_btn      = b;
    model_update(r, st, sz, sp, b);
  endtask

  initial begin
    bit b;
    int max_end;
    int held_pos;
    reset             = 1'b1;
    bus.start_level   = 1'b0;
    bus.block_size_in = '0;
    bus.speed         = '0;
    bus.stop_btn      = 1'b0;
    model_update(1, 0, 0, 0, 0);

    // Reset for two cycles, then release
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_val("rst_start", 32'(bus.curr_block_start), 0);
    check_val("rst_moving", 32'(bus.moving), 0);

    // Load size 2 at speed 0: step after four cycles
    cyc(0, 1, 2, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_val("load_start", 32'(bus.curr_block_start), 0);
    check_val("load_end", 32'(bus.curr_block_end), 15);
    check_val("load_moving", 32'(bus.moving), 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    check_val("step1_start", 32'(bus.curr_block_start), 8);
    check_val("step1_end", 32'(bus.curr_block_end), 23);

    // Full bounce right and back; end must never pass the wall
    max_end = 0;
    for (int i = 0; i < 120; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (int'(bus.curr_block_end) > max_end) max_end = int'(bus.curr_block_end);
    end
    check_val("bounce_max_end", 32'(max_end), 63);

    // Stop and hold the button: position frozen, no retrigger
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    held_pos = int'(bus.curr_block_start);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    check_val("stop_true_held", 32'(bus.stop_true), 1);
    check_val("stop_pos_held", 32'(bus.curr_block_start), 32'(held_pos));
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check_val("reload_end", 32'(bus.curr_block_end), 7);
    check_val("reload_stop_true", 32'(bus.stop_true), 0);

    // Reset mid-move
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_val("midrst_end", 32'(bus.curr_block_end), 0);

    // Game over, then full-width block that never moves
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_val("gameover_moving", 32'(bus.moving), 0);
    cyc(0, 1, 8, 2, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0);
    check_val("fullw_start", 32'(bus.curr_block_start), 0);
    check_val("fullw_end", 32'(bus.curr_block_end), 63);

    // Random play
    b = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, st;
      int sz, sp;
      if ($urandom_range(0, 29) == 0) b = ~b;
      r  = ($urandom_range(0, 599) == 0);
      st = ($urandom_range(0, 79) == 0);
      sz = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 6));
      sp = int'($urandom_range(0, 3));
      cyc(r, st, sz, sp, b);
    end
    cyc(0, 0, 0, 0, b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
